reg64_unpack: RTL and testbench

Reader-side companion to the 64-bit storage register. It drains 64-bit values, such as multiplier/divider products or 64-bit pipeline-latch contents, into a 32-bit datapath as two sequential 32-bit words over a valid/ready handshake. A one-entry pending buffer lets the producer hand over the next 64-bit word while the current one is still being emitted. It sits between any 64-bit producer and the 32-bit writeback/bus path.

---
 rtl/reg64_unpack.sv | 90 +++++++++
 tb/tb_reg64_unpack.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg64_unpack.sv
// reg64_unpack: drains 64-bit words into a 32-bit stream as two halves over valid/ready
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   in_data/valid/ready   : 64-bit producer handshake (one-entry pending buffer behind cur)
//   out_data/valid/ready  : 32-bit consumer handshake; out_data is 0 while idle
//   out_last          : second half of the current 64-bit word is presented
//   busy              : a word is being emitted or waiting in the pending buffer
//   words_sent        : wrapping count of completed 32-bit output handshakes
module reg64_unpack #(
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic [15:0] words_sent
);
   typedef enum logic [1:0] {IDLE, FIRST, SECOND} unpackState;
   unpackState state, stateNext;
   logic [63:0] cur, curNext, pend, pendNext;
   logic        pendValid, pendValidNext;
   logic        accIn, accOut;
   logic [31:0] firstHalf, secondHalf;
   assign in_ready   = !pendValid && !reset;
   assign out_valid  = (state != IDLE);
   assign out_last   = (state == SECOND);
   assign busy       = out_valid || pendValid;
   assign accIn      = in_valid && in_ready;
   assign accOut     = out_valid && out_ready;
   assign firstHalf  = HIGH_FIRST ? cur[63:32] : cur[31:0];
   assign secondHalf = HIGH_FIRST ? cur[31:0] : cur[63:32];
   assign out_data   = (state == FIRST) ? firstHalf : (state == SECOND) ? secondHalf : 32'h0;
   always_comb begin
      stateNext     = state;
      curNext       = cur;
      pendNext      = pend;
      pendValidNext = pendValid;
      case (state)
         IDLE: if (accIn) begin
            curNext   = in_data;
            stateNext = FIRST;
         end
         FIRST: begin
            if (accOut) stateNext = SECOND;
            if (accIn) begin
               pendNext      = in_data;
               pendValidNext = 1'b1;
            end
         end
         SECOND: if (accOut) begin
            // pending word outranks a same-cycle input; in_ready is low then anyway
            if (pendValid) begin
               curNext       = pend;
               pendValidNext = 1'b0;
               stateNext     = FIRST;
            end else if (accIn) begin
               curNext   = in_data;
               stateNext = FIRST;
            end else begin
               stateNext = IDLE;
            end
         end else if (accIn) begin
            pendNext      = in_data;
            pendValidNext = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cur        <= 64'h0;
         pend       <= 64'h0;
         pendValid  <= 1'b0;
         words_sent <= 16'h0;
      end else begin
         state      <= stateNext;
         cur        <= curNext;
         pend       <= pendNext;
         pendValid  <= pendValidNext;
         words_sent <= words_sent + {15'h0, accOut};
      end
   end
endmodule

// File: tb/tb_reg64_unpack.sv
// tb_reg64_unpack: scoreboard bench for reg64_unpack (both half orders)
module tb_reg64_unpack;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data = 64'h0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, out_last, busy;
   logic [31:0] out_data;
   logic [15:0] words_sent;
   logic        hfInReady, hfOutValid, hfOutLast, hfBusy;
   logic [31:0] hfOutData;
   logic [15:0] hfWordsSent;
   logic [32:0] expQ[$];
   logic [15:0] expWs = 16'h0;
   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   reg64_unpack #(.HIGH_FIRST(1'b0)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .words_sent(words_sent));

   reg64_unpack #(.HIGH_FIRST(1'b1)) dutHi (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(hfInReady),
      .out_data(hfOutData), .out_valid(hfOutValid), .out_ready(out_ready), .out_last(hfOutLast),
      .busy(hfBusy), .words_sent(hfWordsSent));

   task automatic pushWord(input logic [63:0] w);
      expQ.push_back({1'b0, w[31:0]});
      expQ.push_back({1'b1, w[63:32]});
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b1; in_data = 64'hDEADBEEF_CAFEF00D; out_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      compared++;
      if ({out_valid, out_last, busy, in_ready} !== 4'b0) begin
         mismatched++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_last, busy, in_ready});
      end
      compared++;
      if (out_data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h expected 0", out_data); end
      compared++;
      if (words_sent !== 16'h0) begin mismatched++; $display("FAIL reset_count: got %h expected 0", words_sent); end
      compared++;
      if ({hfOutValid, hfBusy, hfInReady} !== 3'b0) begin
         mismatched++; $display("FAIL reset_hi_flags: got %b expected 000", {hfOutValid, hfBusy, hfInReady});
      end
      reset = 1'b0; in_valid = 1'b0; #1;
      compared++;
      if ({in_ready, hfInReady} !== 2'b11) begin
         mismatched++; $display("FAIL ready_after_reset: got %b expected 11", {in_ready, hfInReady});
      end
      expWs = 16'h0;
   endtask

   task automatic test_single_word;
      @(negedge clock);
      in_data = 64'h11223344_AABBCCDD; in_valid = 1'b1; out_ready = 1'b1; #1;
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      @(posedge clock); @(negedge clock);
      in_valid = 1'b0; #1;
      compared++;
      if ({out_valid, out_last, out_data} !== {2'b10, 32'hAABBCCDD}) begin
         mismatched++; $display("FAIL single_first: got %b%b %h expected 10 aabbccdd", out_valid, out_last, out_data);
      end
      compared++;
      if ({hfOutValid, hfOutLast, hfOutData} !== {2'b10, 32'h11223344}) begin
         mismatched++; $display("FAIL hi_first: got %b%b %h expected 10 11223344", hfOutValid, hfOutLast, hfOutData);
      end
      @(posedge clock); @(negedge clock); #1;
      compared++;
      if ({out_valid, out_last, out_data} !== {2'b11, 32'h11223344}) begin
         mismatched++; $display("FAIL single_second: got %b%b %h expected 11 11223344", out_valid, out_last, out_data);
      end
      compared++;
      if ({hfOutValid, hfOutLast, hfOutData} !== {2'b11, 32'hAABBCCDD}) begin
         mismatched++; $display("FAIL hi_second: got %b%b %h expected 11 aabbccdd", hfOutValid, hfOutLast, hfOutData);
      end
      @(posedge clock); @(negedge clock); #1;
      expWs = expWs + 16'd2;
      compared++;
      if ({out_valid, hfOutValid} !== 2'b00) begin
         mismatched++; $display("FAIL single_idle: got %b expected 00", {out_valid, hfOutValid});
      end
      compared++;
      if ({words_sent, hfWordsSent} !== {expWs, expWs}) begin
         mismatched++; $display("FAIL single_count: got %h/%h expected %h", words_sent, hfWordsSent, expWs);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] words[4] = '{64'h00000001_00000002, 64'h00000003_00000004,
                                64'h00000005_00000006, 64'h00000007_00000008};
      logic [32:0] exp;
      int idx = 0, got = 0, cyc = 0;
      bit started = 0, acc;
      out_ready = 1'b1;
      while (got < 8 && cyc < 60) begin
         in_valid = (idx < 4);
         in_data = words[idx < 4 ? idx : 3];
         #1;
         acc = in_valid && in_ready;
         if (acc) pushWord(in_data);
         if (started) begin
            compared++;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_gap: got out_valid %b expected 1 at output %0d", out_valid, got); end
         end
         if (out_valid) begin
            started = 1;
            exp = expQ.size() != 0 ? expQ.pop_front() : 33'hx;
            compared++;
            if ({out_last, out_data} !== exp) begin
               mismatched++; $display("FAIL b2b_data: got %b %h expected %b %h", out_last, out_data, exp[32], exp[31:0]);
            end
            got++; expWs++;
         end
         @(posedge clock);
         if (acc) idx++;
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0; #1;
      compared++;
      if (got != 8) begin mismatched++; $display("FAIL b2b_timeout: got %0d outputs expected 8", got); end
      compared++;
      if (words_sent !== expWs) begin mismatched++; $display("FAIL b2b_count: got %h expected %h", words_sent, expWs); end
   endtask

   task automatic test_backpressure;
      logic [63:0] words[3] = '{64'h0BADF00D_12345678, 64'hFEEDFACE_87654321, 64'hA5A5A5A5_5A5A5A5A};
      logic [32:0] exp;
      int idx = 0, got = 0, cyc = 0;
      bit acc;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 3);
         in_data = words[idx < 3 ? idx : 2];
         #1;
         acc = in_valid && in_ready;
         if (acc) pushWord(in_data);
         if (c >= 1) begin
            compared++;
            if ({out_valid, out_last, out_data} !== {2'b10, words[0][31:0]}) begin
               mismatched++; $display("FAIL bp_hold: got %b%b %h expected 10 %h", out_valid, out_last, out_data, words[0][31:0]);
            end
         end
         @(posedge clock);
         if (acc) idx++;
         @(negedge clock);
      end
      #1;
      compared++;
      if (idx != 2) begin mismatched++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
      compared++;
      if ({in_ready, busy} !== 2'b01) begin mismatched++; $display("FAIL bp_full: got ready/busy %b expected 01", {in_ready, busy}); end
      out_ready = 1'b1;
      while (got < 6 && cyc < 40) begin
         in_valid = (idx < 3);
         in_data = words[idx < 3 ? idx : 2];
         #1;
         acc = in_valid && in_ready;
         if (acc) pushWord(in_data);
         if (out_valid) begin
            exp = expQ.size() != 0 ? expQ.pop_front() : 33'hx;
            compared++;
            if ({out_last, out_data} !== exp) begin
               mismatched++; $display("FAIL bp_data: got %b %h expected %b %h", out_last, out_data, exp[32], exp[31:0]);
            end
            got++; expWs++;
         end
         @(posedge clock);
         if (acc) idx++;
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0; #1;
      compared++;
      if (got != 6 || idx != 3) begin mismatched++; $display("FAIL bp_drain: got %0d outputs %0d accepted expected 6 3", got, idx); end
      compared++;
      if ({in_ready, busy} !== 2'b10) begin mismatched++; $display("FAIL bp_empty: got ready/busy %b expected 10", {in_ready, busy}); end
      compared++;
      if (words_sent !== expWs) begin mismatched++; $display("FAIL bp_count: got %h expected %h", words_sent, expWs); end
   endtask

   task automatic test_reset_mid;
      in_data = 64'h01010101_02020202; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); @(negedge clock);
      in_data = 64'h03030303_04040404;
      @(posedge clock); @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      out_ready = 1'b0; #1;
      compared++;
      if ({out_last, in_ready, busy, out_data} !== {3'b101, 32'h01010101}) begin
         mismatched++; $display("FAIL mid_setup: got %b %h expected 101 01010101", {out_last, in_ready, busy}, out_data);
      end
      expQ.delete();
      reset = 1'b1; in_valid = 1'b1; in_data = 64'h77777777_88888888; out_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      reset = 1'b0; in_valid = 1'b0; #1;
      expWs = 16'h0;
      compared++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         mismatched++; $display("FAIL mid_reset_flags: got %b expected 001", {out_valid, busy, in_ready});
      end
      compared++;
      if (words_sent !== 16'h0) begin mismatched++; $display("FAIL mid_reset_count: got %h expected 0", words_sent); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); @(negedge clock); #1;
         compared++;
         if ({out_valid, out_data} !== 33'h0) begin
            mismatched++; $display("FAIL mid_stale: got %b %h expected 0 0", out_valid, out_data);
         end
      end
   endtask

   task automatic test_wrap;
      int cyc = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      while (expWs !== 16'hFFFF && cyc < 70000) begin
         in_data = {32'(cyc), ~32'(cyc)}; #1;
         if (out_valid) expWs++;
         @(posedge clock); @(negedge clock);
         cyc++;
      end
      #1;
      compared++;
      if (words_sent !== 16'hFFFF) begin mismatched++; $display("FAIL wrap_max: got %h expected ffff", words_sent); end
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("FAIL wrap_valid: got %b expected 1", out_valid); end
      @(posedge clock); @(negedge clock); #1;
      compared++;
      if (words_sent !== 16'h0000) begin mismatched++; $display("FAIL wrap_zero: got %h expected 0000", words_sent); end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_word;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
